ula_arbitro_logico: RTL and testbench

//  Shares one ULA_logico instance (6-bit logic unit, sel 8..15) between two requesters.

---
 rtl/ula_arbitro_logico.sv | 111 +++++++++++
 tb/tb_ula_arbitro_logico.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_arbitro_logico.sv
// Round-robin arbiter sharing one ULA_logico between two requesters, with
// registered ULA operands, a settle counter and a tagged valid/ready response.
module ula_arbitro_logico #(
  parameter int WIDTH       = 6,
  parameter int SEL_W       = 4,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [SEL_W-1:0] req0_sel,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [SEL_W-1:0] req1_sel,
  output logic             req1_ready,
  output logic [WIDTH-1:0] ula_a,
  output logic [WIDTH-1:0] ula_b,
  output logic [SEL_W-1:0] ula_sel,
  input  logic [WIDTH-1:0] ula_saida,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err,
  input  logic             resp_ready,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t           state;
  logic             rr_last;
  logic [3:0]       cnt;
  logic             grant1;
  logic             accept;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [SEL_W-1:0] sel_in;

  // rr_last holds the id served last; on a tie the other requester wins.
  always_comb begin
    grant1     = req1_valid & (~req0_valid | ~rr_last);
    accept     = (state == IDLE) & (req0_valid | req1_valid);
    req0_ready = (state == IDLE) & req0_valid & ~grant1;
    req1_ready = (state == IDLE) & grant1;
    a_in       = grant1 ? req1_a   : req0_a;
    b_in       = grant1 ? req1_b   : req0_b;
    sel_in     = grant1 ? req1_sel : req0_sel;
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_last    <= 1'b1;
      cnt        <= '0;
      ula_a      <= '0;
      ula_b      <= '0;
      ula_sel    <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            resp_id <= grant1;
            // Non-logic selects never reach the ULA; answer with an error at once.
            if (!sel_in[SEL_W-1]) begin
              resp_err   <= 1'b1;
              resp_data  <= '0;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              ula_a   <= a_in;
              ula_b   <= b_in;
              ula_sel <= sel_in;
              cnt     <= CNT_INIT;
              state   <= EXEC;
            end
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            resp_data  <= ula_saida;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            rr_last    <= resp_id;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_arbitro_logico.sv
// Directed bench for ula_arbitro_logico: two arbiter instances (1 and 4 settle
// cycles), each driving a behavioural ULA_logico model.
module tb_ula_arbitro_logico;

  localparam int W = 6;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  int           total = 0;
  int           bad   = 0;

  // Instance with EXEC_CYCLES=1
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [S-1:0] req0_sel, req1_sel;
  logic [W-1:0] ula_a, ula_b, ula_saida, resp_data;
  logic [S-1:0] ula_sel;
  logic         resp_valid, resp_id, resp_err, resp_ready, busy;

  // Instance with EXEC_CYCLES=4
  logic         q0_valid, q0_ready, q1_valid, q1_ready;
  logic [W-1:0] q0_a, q0_b;
  logic [S-1:0] q0_sel;
  logic [W-1:0] u4_a, u4_b, u4_saida, r4_data;
  logic [S-1:0] u4_sel;
  logic         r4_valid, r4_id, r4_err, r4_ready, busy4;

  function automatic logic [W-1:0] ula_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [S-1:0] sel);
    case (sel)
      4'd8:    return a & b;
      4'd9:    return a | b;
      4'd10:   return a ^ b;
      4'd11:   return ~(a & b);
      4'd12:   return ~(a | b);
      4'd13:   return ~(a ^ b);
      4'd14:   return ~a;
      4'd15:   return b;
      default: return '0;
    endcase
  endfunction

  assign ula_saida = ula_ref(ula_a, ula_b, ula_sel);
  assign u4_saida  = ula_ref(u4_a, u4_b, u4_sel);

  ula_arbitro_logico #(.WIDTH(W), .SEL_W(S), .EXEC_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .req1_ready(req1_ready),
    .ula_a(ula_a), .ula_b(ula_b), .ula_sel(ula_sel), .ula_saida(ula_saida),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .resp_err(resp_err), .resp_ready(resp_ready), .busy(busy)
  );

  ula_arbitro_logico #(.WIDTH(W), .SEL_W(S), .EXEC_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(q0_valid), .req0_a(q0_a), .req0_b(q0_b), .req0_sel(q0_sel),
    .req0_ready(q0_ready),
    .req1_valid(q1_valid), .req1_a(6'd0), .req1_b(6'd0), .req1_sel(4'd0),
    .req1_ready(q1_ready),
    .ula_a(u4_a), .ula_b(u4_b), .ula_sel(u4_sel), .ula_saida(u4_saida),
    .resp_valid(r4_valid), .resp_id(r4_id), .resp_data(r4_data),
    .resp_err(r4_err), .resp_ready(r4_ready), .busy(busy4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ea, eb, ra, rb;
    logic [S-1:0] esel, saved_sel;
    logic         exp_id;

    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; req0_a = 0; req0_b = 0; req0_sel = 0;
    req1_a = 0; req1_b = 0; req1_sel = 0; resp_ready = 1;
    q0_valid = 0; q1_valid = 0; q0_a = 0; q0_b = 0; q0_sel = 0; r4_ready = 1;

    // Reset state
    tick(); tick();
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ula_a", ula_a, 0);
    chk("rst_ula_sel", ula_sel, 0);
    chk("rst_resp_data", resp_data, 0);
    rst_n = 1'b1;
    tick();

    // T1: single logic op from req0
    req0_valid = 1; req0_a = 6'b101100; req0_b = 6'b011010; req0_sel = 4'b1000;
    #1;
    chk("t1_ready0", req0_ready, 1);
    chk("t1_ready1", req1_ready, 0);
    tick();
    req0_valid = 0;
    chk("t1_exec_busy", busy, 1);
    chk("t1_exec_valid", resp_valid, 0);
    chk("t1_ula_a", ula_a, 6'b101100);
    chk("t1_ula_sel", ula_sel, 4'b1000);
    tick();
    chk("t1_resp_valid", resp_valid, 1);
    chk("t1_resp_id", resp_id, 0);
    chk("t1_resp_data", resp_data, 6'b001000);
    chk("t1_resp_err", resp_err, 0);
    tick();
    chk("t1_after_valid", resp_valid, 0);
    chk("t1_after_busy", busy, 0);

    // T2: both requesters valid continuously, grants must alternate (req0 served last)
    exp_id = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req0_valid = 1; req1_valid = 1;
      req0_a = 6'(i * 7 + 3);  req0_b = 6'(i * 11 + 5);
      req1_a = 6'(i * 13 + 1); req1_b = 6'(i * 3 + 9);
      esel = 4'(8 + ((i + 1) % 8));
      req0_sel = esel; req1_sel = esel;
      ea = exp_id ? req1_a : req0_a;
      eb = exp_id ? req1_b : req0_b;
      #1;
      chk($sformatf("t2_ready0_%0d", i), req0_ready, !exp_id);
      chk($sformatf("t2_ready1_%0d", i), req1_ready, exp_id);
      tick();
      chk($sformatf("t2_exec_ready_%0d", i), {req0_ready, req1_ready}, 0);
      tick();
      chk($sformatf("t2_valid_%0d", i), resp_valid, 1);
      chk($sformatf("t2_id_%0d", i), resp_id, exp_id);
      chk($sformatf("t2_data_%0d", i), resp_data, ula_ref(ea, eb, esel));
      tick();
      exp_id = ~exp_id;
    end
    req0_valid = 0; req1_valid = 0;
    tick();

    // T3: error command from req1 bypasses the ULA
    saved_sel = 4'd8;
    req1_valid = 1; req1_a = 6'h15; req1_b = 6'h2a; req1_sel = 4'b0011;
    #1;
    chk("t3_ready1", req1_ready, 1);
    tick();
    req1_valid = 0;
    chk("t3_resp_valid", resp_valid, 1);
    chk("t3_resp_err", resp_err, 1);
    chk("t3_resp_data", resp_data, 0);
    chk("t3_resp_id", resp_id, 1);
    chk("t3_ula_sel", ula_sel, saved_sel);
    tick();
    chk("t3_after_valid", resp_valid, 0);

    // T4: response back-pressure for 5 cycles
    resp_ready = 0;
    req0_valid = 1; req0_a = 6'h33; req0_b = 6'h0f; req0_sel = 4'd10;
    #1;
    chk("t4_ready0", req0_ready, 1);
    tick();
    req1_valid = 1;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t4_valid_%0d", k), resp_valid, 1);
      chk($sformatf("t4_id_%0d", k), resp_id, 0);
      chk($sformatf("t4_data_%0d", k), resp_data, 6'h3c);
      chk($sformatf("t4_ready_%0d", k), {req0_ready, req1_ready}, 0);
      chk($sformatf("t4_busy_%0d", k), busy, 1);
      if (k < 4) tick();
    end
    req0_valid = 0; req1_valid = 0; resp_ready = 1;
    tick();
    chk("t4_release_valid", resp_valid, 0);
    chk("t4_release_busy", busy, 0);

    // T5: reset in EXEC drops the transaction and restores req0 priority
    req1_valid = 1; req1_a = 6'h21; req1_b = 6'h12; req1_sel = 4'd12;
    #1;
    chk("t5_ready1", req1_ready, 1);
    tick();
    req1_valid = 0;
    chk("t5_exec_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_valid", resp_valid, 0);
    chk("t5_rst_ula_a", ula_a, 0);
    chk("t5_rst_ula_sel", ula_sel, 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t5_no_resp_%0d", k), resp_valid, 0);
    end
    req0_valid = 1; req1_valid = 1;
    req0_a = 6'h2d; req0_b = 6'h16; req0_sel = 4'd9;
    req1_a = 6'h01; req1_b = 6'h02; req1_sel = 4'd9;
    #1;
    chk("t5_post_ready0", req0_ready, 1);
    chk("t5_post_ready1", req1_ready, 0);
    tick();
    req0_valid = 0; req1_valid = 0;
    tick();
    chk("t5_post_id", resp_id, 0);
    chk("t5_post_data", resp_data, 6'h3f);
    tick();

    // T6: four settle cycles, 5 random operand pairs over every logic select
    for (int p = 0; p < 5; p++) begin
      ra = 6'($urandom_range(0, 63));
      rb = 6'($urandom_range(0, 63));
      for (int s = 8; s < 16; s++) begin
        q0_valid = 1; q0_a = ra; q0_b = rb; q0_sel = 4'(s);
        #1;
        chk($sformatf("t6_ready_%0d_%0d", p, s), q0_ready, 1);
        tick();
        q0_valid = 0;
        for (int c = 1; c <= 4; c++) begin
          chk($sformatf("t6_hold_%0d_%0d_%0d", p, s, c), {u4_a, u4_b, u4_sel}, {ra, rb, 4'(s)});
          chk($sformatf("t6_early_%0d_%0d_%0d", p, s, c), r4_valid, 0);
          tick();
        end
        chk($sformatf("t6_valid_%0d_%0d", p, s), r4_valid, 1);
        chk($sformatf("t6_data_%0d_%0d", p, s), r4_data, ula_ref(ra, rb, 4'(s)));
        chk($sformatf("t6_err_%0d_%0d", p, s), r4_err, 0);
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
